// File: rtl/vga_pixel_fetch.sv
// vga_pixel_fetch: prefetches framebuffer pixels into a small FIFO and hands
// one 12-bit RGB pixel per active-pixel request to the VGA timing stage.
// Credits (stored + in flight) bound the reads, so the FIFO cannot overflow
// whatever the memory latency is.
module vga_pixel_fetch #(
   parameter int H_ACTIVE   = 800,
   parameter int V_ACTIVE   = 600,
   parameter int ADDR_W     = 19,
   parameter int DATA_W     = 12,
   parameter int FIFO_DEPTH = 16
) (
   input  logic              MAX10_CLK1_50,
   input  logic              rst,
   input  logic              frame_start,
   input  logic              pix_req,
   output logic [DATA_W-1:0] pix_rgb,
   output logic              pix_valid,
   output logic              underflow,
   output logic              mem_rd,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_ready,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_rvalid
);

   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int CNT_W  = PTR_W + 1;
   // Stale reads can pile up if frame_start arrives repeatedly with reads in flight.
   localparam int DROP_W = CNT_W + 4;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);
   localparam logic [CNT_W:0]    DEPTH_C   = (CNT_W+1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

   state_t            state, state_nxt;
   logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic [CNT_W-1:0]  fifo_count;
   logic [CNT_W-1:0]  outstanding;
   logic [DROP_W-1:0] drop;
   logic [CNT_W:0]    occupancy;
   logic              accept;
   logic              ret_drop;
   logic              ret_push;
   logic              fifo_empty;
   logic              do_push;
   logic              do_pop;

   // Words stored plus words still owed by memory for the current frame.
   assign occupancy  = {1'b0, fifo_count} + {1'b0, outstanding};
   assign accept     = mem_rd & mem_ready;
   // Returns belonging to a flushed frame are consumed first; returns with no
   // credit at all are spurious and ignored.
   assign ret_drop   = mem_rvalid && (drop != '0);
   assign ret_push   = mem_rvalid && (drop == '0) && (outstanding != '0);
   assign fifo_empty = (fifo_count == '0);
   // frame_start flushes the FIFO, so it suppresses both push and pop.
   assign do_push    = ret_push && !frame_start;
   assign do_pop     = pix_req && !frame_start && !fifo_empty;

   // State register.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of block evaluation order.
   always_ff @(posedge MAX10_CLK1_50) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state and read-request decode.
   always_comb begin
      // NOTE: defaults first so every path assigns every output; no latches.
      state_nxt = state;
      mem_rd    = 1'b0;
      case (state)
         IDLE: ;
         FILL: begin
            mem_rd = (occupancy < DEPTH_C);
            if (mem_rd && mem_ready && (mem_addr == LAST_ADDR)) state_nxt = DONE;
         end
         DONE: ;
         default: state_nxt = IDLE;
      endcase
      if (frame_start) state_nxt = FILL;
   end

   // Read address and credit accounting.
   always_ff @(posedge MAX10_CLK1_50) begin
      if (rst) begin
         mem_addr    <= '0;
         outstanding <= '0;
         drop        <= '0;
      end else if (frame_start) begin
         mem_addr    <= '0;
         outstanding <= '0;
         // Everything still owed after this edge belongs to the old frame.
         drop        <= drop + DROP_W'(outstanding) + DROP_W'(accept)
                        - DROP_W'(ret_drop) - DROP_W'(ret_push);
      end else begin
         if (accept) mem_addr <= mem_addr + ADDR_W'(1);
         outstanding <= outstanding + CNT_W'(accept) - CNT_W'(ret_push);
         drop        <= drop - DROP_W'(ret_drop);
      end
   end

   // FIFO pointers and fill level.
   always_ff @(posedge MAX10_CLK1_50) begin
      if (rst || frame_start) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         fifo_count <= fifo_count + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   // FIFO storage.
   // NOTE: the data array has no reset; the pointers and count define which
   // words are meaningful, and leaving it unreset lets it map to block RAM.
   always_ff @(posedge MAX10_CLK1_50) begin
      if (do_push) fifo_mem[wr_ptr] <= mem_rdata;
   end

   // Pixel output stage, one cycle after pix_req.
   always_ff @(posedge MAX10_CLK1_50) begin
      if (rst) begin
         pix_rgb   <= '0;
         pix_valid <= 1'b0;
         underflow <= 1'b0;
      end else if (frame_start) begin
         pix_valid <= 1'b0;
         if (pix_req) pix_rgb <= '0;
      end else if (pix_req) begin
         if (!fifo_empty) begin
            pix_rgb   <= fifo_mem[rd_ptr];
            pix_valid <= 1'b1;
         end else begin
            pix_rgb   <= '0;
            pix_valid <= 1'b0;
            underflow <= 1'b1;
         end
      end else begin
         pix_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Bench for vga_pixel_fetch: a reduced 800x4 frame keeps a full frame short.
// An in-order framebuffer model with variable latency feeds the DUT, and a
// frame/epoch-based model predicts every output each cycle.
module tb_vga_pixel_fetch;

   localparam int H     = 800;
   localparam int V     = 4;
   localparam int AW    = 19;
   localparam int DW    = 12;
   localparam int DEPTH = 16;
   localparam int NPIX  = H * V;

   logic          MAX10_CLK1_50 = 1'b0;
   logic          rst = 1'b1, frame_start = 1'b0, pix_req = 1'b0, mem_ready = 1'b0;
   logic          mem_rvalid = 1'b0;
   logic [DW-1:0] mem_rdata = '0;
   logic [DW-1:0] pix_rgb;
   logic          pix_valid, underflow, mem_rd;
   logic [AW-1:0] mem_addr;

   always #10 MAX10_CLK1_50 = ~MAX10_CLK1_50;

   vga_pixel_fetch #(
      .H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH)
   ) dut (
      .MAX10_CLK1_50(MAX10_CLK1_50), .rst(rst), .frame_start(frame_start),
      .pix_req(pix_req), .pix_rgb(pix_rgb), .pix_valid(pix_valid),
      .underflow(underflow), .mem_rd(mem_rd), .mem_addr(mem_addr),
      .mem_ready(mem_ready), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid)
   );

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Framebuffer contents: a fixed, address-dependent pattern.
   function automatic logic [DW-1:0] pix_of(input int a);
      logic [31:0] v;
      v = a * 37 + (a >> 5) * 11 + 5;
      return v[DW-1:0];
   endfunction

   // ---------------- reference model ----------------
   typedef struct {int addr; int epoch; int due;} req_t;
   req_t          ret_q[$];   // accepted reads, in return order
   int            avail[$];   // addresses of pixels held for the timing stage
   int            cyc = 0, epoch = 0, next_addr = 0, frame_acc = 0, last_acc = -1;
   int            lat_min = 3, lat_max = 3;
   bit            fill = 0, model_live = 0, exp_valid = 0, exp_uf = 0;
   logic [DW-1:0] exp_rgb = '0;

   function automatic int inflight_cur();
      int n = 0;
      foreach (ret_q[i]) if (ret_q[i].epoch == epoch) n++;
      return n;
   endfunction

   always @(posedge MAX10_CLK1_50) begin : model
      req_t r;
      bit   got_ret;
      cyc++;
      if (rst) begin
         model_live = 1;
         ret_q.delete();
         avail.delete();
         fill = 0; next_addr = 0; frame_acc = 0;
         exp_valid = 0; exp_rgb = '0; exp_uf = 0;
      end else begin
         got_ret = 0;
         if (mem_rvalid && ret_q.size() > 0) begin
            r = ret_q.pop_front();
            got_ret = 1;
         end
         if (frame_start) begin
            exp_valid = 0;
            if (pix_req) exp_rgb = '0;
         end else if (pix_req) begin
            if (avail.size() == 0) begin
               exp_valid = 0; exp_rgb = '0; exp_uf = 1;
            end else begin
               exp_valid = 1; exp_rgb = pix_of(avail.pop_front());
            end
         end else begin
            exp_valid = 0;
         end
         if (got_ret && !frame_start && r.epoch == epoch) avail.push_back(r.addr);
         if (mem_rd && mem_ready) begin
            ret_q.push_back('{addr: int'(mem_addr), epoch: epoch,
                              due: cyc + int'($urandom_range(lat_max, lat_min))});
            last_acc = int'(mem_addr);
            frame_acc++;
            next_addr++;
            if (next_addr == NPIX) fill = 0;
         end
         if (frame_start) begin
            epoch++;
            avail.delete();
            fill = 1; next_addr = 0; frame_acc = 0;
         end
      end
   end

   // Framebuffer return side: present the oldest read once its latency has elapsed.
   always @(negedge MAX10_CLK1_50) begin
      if (ret_q.size() > 0 && ret_q[0].due <= cyc) begin
         mem_rvalid = 1'b1;
         mem_rdata  = pix_of(ret_q[0].addr);
      end else begin
         mem_rvalid = 1'b0;
         mem_rdata  = DW'($urandom);
      end
   end

   // Cycle-by-cycle comparison against the model.
   always @(negedge MAX10_CLK1_50) begin
      if (model_live) begin
         check("mon_pix_valid", pix_valid, exp_valid);
         check("mon_pix_rgb", pix_rgb, exp_rgb);
         check("mon_underflow", underflow, exp_uf);
         check("mon_mem_rd", mem_rd, fill && (avail.size() + inflight_cur()) < DEPTH);
         check("mon_mem_addr", mem_addr, next_addr);
      end
   end

   // ---------------- stimulus ----------------
   task automatic drive(input bit r, input bit fs, input bit rq, input bit rdy);
      rst = r; frame_start = fs; pix_req = rq; mem_ready = rdy;
   endtask

   task automatic tick();
      @(negedge MAX10_CLK1_50);
   endtask

   typedef struct {
      bit r, fs, rq, rdy;
      bit e_valid; logic [DW-1:0] e_rgb; bit e_uf, e_rd; int e_addr;
   } vec_t;
   vec_t vecs[13];

   initial begin : watchdog
      #1_500_000;
      $display("FAIL watchdog: simulation did not end within the time limit");
      $fatal(1);
   end

   initial begin : main
      int budget;
      // rst  fs  rq rdy | valid rgb uf rd addr
      vecs[0]  = '{1, 0, 0, 0,  0, 0, 0, 0, 0};  // reset values
      vecs[1]  = '{1, 0, 0, 0,  0, 0, 0, 0, 0};
      vecs[2]  = '{0, 0, 0, 0,  0, 0, 0, 0, 0};  // IDLE issues no reads
      vecs[3]  = '{0, 0, 1, 0,  0, 0, 1, 0, 0};  // request on empty FIFO
      vecs[4]  = '{0, 0, 0, 0,  0, 0, 1, 0, 0};  // underflow sticky
      vecs[5]  = '{1, 0, 0, 0,  0, 0, 0, 0, 0};  // only rst clears it
      vecs[6]  = '{0, 1, 1, 0,  0, 0, 0, 1, 0};  // frame_start wins over pix_req
      vecs[7]  = '{0, 0, 0, 0,  0, 0, 0, 1, 0};  // read held until accepted
      vecs[8]  = '{0, 0, 1, 0,  0, 0, 1, 1, 0};
      vecs[9]  = '{0, 0, 0, 1,  0, 0, 1, 1, 1};  // accept advances address
      vecs[10] = '{0, 0, 0, 1,  0, 0, 1, 1, 2};
      vecs[11] = '{1, 0, 0, 0,  0, 0, 0, 0, 0};  // rst mid-frame with reads in flight
      vecs[12] = '{0, 0, 0, 0,  0, 0, 0, 0, 0};
      lat_min = 3; lat_max = 3;
      foreach (vecs[i]) begin
         drive(vecs[i].r, vecs[i].fs, vecs[i].rq, vecs[i].rdy);
         tick();
         check($sformatf("vec%0d_pix_valid", i), pix_valid, vecs[i].e_valid);
         check($sformatf("vec%0d_pix_rgb", i), pix_rgb, vecs[i].e_rgb);
         check($sformatf("vec%0d_underflow", i), underflow, vecs[i].e_uf);
         check($sformatf("vec%0d_mem_rd", i), mem_rd, vecs[i].e_rd);
         check($sformatf("vec%0d_mem_addr", i), mem_addr, vecs[i].e_addr);
      end

      // Reset + start: reads stop once 16 credits are used.
      drive(1, 0, 0, 0); tick(); tick();
      drive(0, 1, 0, 1); tick();
      drive(0, 0, 0, 1); repeat (40) tick();
      check("t1_accepts", frame_acc, DEPTH);
      check("t1_mem_rd_stalled", mem_rd, 0);
      check("t1_mem_addr", mem_addr, DEPTH);

      // Stream 800 pixels back to back.
      drive(0, 0, 1, 1);
      for (int i = 0; i < H; i++) begin
         tick();
         check("t2_pix_valid", pix_valid, 1);
         check("t2_pix_rgb", pix_rgb, pix_of(i));
      end
      drive(0, 0, 0, 1);
      check("t2_no_underflow", underflow, 0);

      // Underflow with memory stalled since frame_start.
      drive(1, 0, 0, 0); tick();
      drive(0, 1, 0, 0); tick();
      drive(0, 0, 0, 0); repeat (3) tick();
      drive(0, 0, 1, 0); tick();
      check("t3_pix_valid", pix_valid, 0);
      check("t3_pix_rgb", pix_rgb, 0);
      check("t3_underflow", underflow, 1);
      drive(0, 0, 0, 1); repeat (30) tick();
      drive(0, 0, 1, 1); tick();
      check("t3_recover_valid", pix_valid, 1);
      check("t3_recover_rgb", pix_rgb, pix_of(0));
      drive(0, 0, 0, 1); repeat (5) tick();
      check("t3_underflow_sticky", underflow, 1);
      drive(1, 0, 0, 0); tick();
      check("t3_underflow_cleared", underflow, 0);

      // Flush with 5 reads in flight: their returns must be discarded.
      lat_min = 8; lat_max = 8;
      drive(0, 1, 0, 0); tick();
      drive(0, 0, 0, 1); repeat (5) tick();
      check("t4_inflight_accepts", frame_acc, 5);
      drive(0, 1, 0, 0); tick();
      drive(0, 0, 0, 1); repeat (40) tick();
      drive(0, 0, 1, 1);
      for (int i = 0; i < DEPTH; i++) begin
         tick();
         check("t4_pix_valid", pix_valid, 1);
         check("t4_pix_rgb", pix_rgb, pix_of(i));
      end
      drive(0, 0, 0, 1);
      check("t4_underflow", underflow, 0);

      // Full frame under random stalls and latency 1..8.
      drive(1, 0, 0, 0); tick();
      lat_min = 1; lat_max = 8;
      drive(0, 1, 0, 0); tick();
      budget = 0;
      while (frame_acc < NPIX && budget < 40000) begin
         drive(0, 0, $urandom_range(0, 9) < 4, 1'($urandom_range(0, 1)));
         tick();
         budget++;
      end
      check("t6_frame_complete", frame_acc, NPIX);
      check("t5_last_addr", last_acc, NPIX - 1);
      for (int i = 0; i < 30; i++) begin
         drive(0, 0, 0, 1'($urandom_range(0, 1)));
         tick();
         check("t5_done_no_rd", mem_rd, 0);
      end

      // frame_start together with pix_req while the FIFO holds data.
      drive(0, 0, 0, 0); repeat (20) tick();
      drive(0, 1, 1, 0); tick();
      check("fs_req_pix_valid", pix_valid, 0);
      check("fs_req_pix_rgb", pix_rgb, 0);
      check("fs_req_mem_rd", mem_rd, 1);
      check("fs_req_mem_addr", mem_addr, 0);
      drive(0, 0, 1, 0); tick();
      check("fs_flushed_valid", pix_valid, 0);
      check("fs_flushed_underflow", underflow, 1);
      drive(0, 0, 0, 0); tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
